// File: rtl/cascade_pkg.sv
// ============================================================================
// Module   : cascade_pkg
// Brief    : Shared state encoding and default widths for tick_cascade_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cascade_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int RND_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mod_wrap_cnt.sv
// ============================================================================
// Module   : mod_wrap_cnt
// Brief    : Enable-plus-clear modulo counter; wrap flags the enabled last step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        wrap  = en && !clr && (cnt_q == modulus - C_ONE);
        cnt_d = cnt_q;
        if (clr || wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/tick_cascade_cnt.sv
// ============================================================================
// Module   : tick_cascade_cnt
// Brief    : Second-stage tick counter running a latched number of rounds.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_cascade_cnt
    import cascade_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] ceil,
    input  logic [RND_W-1:0] rounds,
    output logic [CNT_W-1:0] cnt,
    output logic             co,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   ceil_q, ceil_d;
    logic [RND_W-1:0]   rounds_q, rounds_d;
    logic               co_q, co_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_run;
    logic               start_ok;
    logic               cnt_clr;
    logic               tick_en;
    logic               tick_wrap;
    logic               rnd_wrap;
    // The round index lives inside its counter; only its wrap ends the run.
    logic [RND_W-1:0]   rnd_idx_unused;

    assign in_run   = (state_q == ST_RUN);
    assign start_ok = (state_q == ST_IDLE) && start && !stop
                      && (ceil != '0) && (rounds != '0);
    assign cnt_clr  = start_ok || (in_run && stop);
    assign tick_en  = in_run && !stop && tick_in;

    mod_wrap_cnt #(.W(CNT_W)) u_tick_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (tick_en),
        .modulus (ceil_q),
        .cnt     (cnt),
        .wrap    (tick_wrap)
    );

    mod_wrap_cnt #(.W(RND_W)) u_rnd_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (tick_wrap),
        .modulus (rounds_q),
        .cnt     (rnd_idx_unused),
        .wrap    (rnd_wrap)
    );

    always_comb begin
        state_d  = state_q;
        ceil_d   = ceil_q;
        rounds_d = rounds_q;
        co_d     = tick_wrap;
        done_d   = rnd_wrap;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    ceil_d   = ceil;
                    rounds_d = rounds;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (rnd_wrap) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ceil_q   <= '0;
            rounds_q <= '0;
            co_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ceil_q   <= ceil_d;
            rounds_q <= rounds_d;
            co_q     <= co_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign co   = co_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_cascade_cnt.sv
// ============================================================================
// Module   : tb_tick_cascade_cnt
// Brief    : Scoreboard bench for tick_cascade_cnt with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tick_cascade_cnt;

    localparam int CW = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] ceil = '0;
    logic [RW-1:0] rounds = '0;
    logic [CW-1:0] cnt;
    logic          co;
    logic          busy;
    logic          done;

    tick_cascade_cnt #(.CNT_W(CW), .RND_W(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .start   (start),
        .stop    (stop),
        .ceil    (ceil),
        .rounds  (rounds),
        .cnt     (cnt),
        .co      (co),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cnt;
        int    co;
        int    busy;
        int    done;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock of stimulus; expected outputs are those after the sampling edge.
    task automatic cyc(input logic t, input logic s, input logic p,
                       input int e_cnt, input int e_co, input int e_busy, input int e_done);
        exp_t e;
        @(negedge clk);
        tick_in = t;
        start   = s;
        stop    = p;
        @(posedge clk);
        e.tag  = phase;
        e.cnt  = e_cnt;
        e.co   = e_co;
        e.busy = e_busy;
        e.done = e_done;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, " cnt"},  int'(cnt),  mon_e.cnt);
                chk({mon_e.tag, " co"},   int'(co),   mon_e.co);
                chk({mon_e.tag, " busy"}, int'(busy), mon_e.busy);
                chk({mon_e.tag, " done"}, int'(done), mon_e.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset cnt",  int'(cnt),  0);
        chk("reset co",   int'(co),   0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        phase = "idle_tick";
        cyc(1, 0, 0, 0, 0, 0, 0);

        phase  = "basic";
        ceil   = 4'd12;
        rounds = 4'd2;
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 24; i++) begin
            if (i == 4) cyc(0, 0, 0, 3, 0, 1, 0);
            cyc(1, (i == 5), 0, i % 12, int'(i % 12 == 0), int'(i != 24), int'(i == 24));
        end
        phase = "basic_done_state";
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        phase  = "reprogram";
        ceil   = 4'd12;
        rounds = 4'd1;
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 0, 0, i % 12, int'(i == 12), int'(i != 12), int'(i == 12));
            if (i == 5) begin
                ceil   = 4'd6;
                rounds = 4'd2;
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        phase = "ceil6";
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 0, 0, i % 6, int'(i % 6 == 0), int'(i != 12), int'(i == 12));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);

        phase  = "stop";
        ceil   = 4'd12;
        rounds = 4'd2;
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) cyc(1, 0, 0, i, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);

        phase  = "degenerate";
        ceil   = 4'd0;
        rounds = 4'd2;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        ceil   = 4'd5;
        rounds = 4'd0;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        rounds = 4'd2;
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        phase  = "ceil1";
        ceil   = 4'd1;
        rounds = 4'd3;
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 0, 1, int'(i != 3), int'(i == 3));
        cyc(1, 0, 0, 0, 0, 0, 0);

        phase  = "async_rst";
        ceil   = 4'd12;
        rounds = 4'd2;
        cyc(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) cyc(1, 0, 0, i, 0, 1, 0);
        @(negedge clk);
        tick_in = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst cnt",  int'(cnt),  5);
        chk("pre_rst busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst cnt",  int'(cnt),  0);
        chk("async_rst co",   int'(co),   0);
        chk("async_rst busy", int'(busy), 0);
        chk("async_rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        phase = "post_rst";
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        tick_in = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        @(posedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
